// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared constants for the processor pipeline stage registers.
//   - Per-stage payload widths (ID/EX, EX/MEM, MEM/WB).
//   - Per-stage control widths and bubble (no-op) control values.
//   - Occupancy state encoding used by pipe_stage_skid.
// No ports; imported with "import pipe_pkg::*;".
// ---------------------------------------------------------------------------
package pipe_pkg;

  // Memory-access no-op encodings.
  // mem_w = 2'b11 is the "no store" code on this datapath.
  localparam logic [1:0] MEM_W_NOP = 2'b11;
  localparam logic [1:0] MEM_R_NOP = 2'b00;

  // Payload widths per stage.
  localparam int IDEX_DATA_W  = 192;
  localparam int EXMEM_DATA_W = 160;
  localparam int MEMWB_DATA_W = 96;

  // EX/MEM control layout: [11:8] rd, [7:6] mem_w, [5:4] mem_r,
  // [3] reg_w, [2:0] branch. The bubble writes no register and touches no
  // memory, which gives 12'h0C0.
  localparam int              EXMEM_CTRL_W      = 12;
  localparam logic [11:0]     EXMEM_CTRL_BUBBLE = {4'h0, MEM_W_NOP, MEM_R_NOP, 1'b0, 3'b000};

  // ID/EX carries four extra ALU-op bits above the EX/MEM control field.
  localparam int              IDEX_CTRL_W       = 16;
  localparam logic [15:0]     IDEX_CTRL_BUBBLE  = {4'h0, EXMEM_CTRL_BUBBLE};

  // MEM/WB only needs rd and reg_w; all-zero is a no-op.
  localparam int              MEMWB_CTRL_W      = 8;
  localparam logic [7:0]      MEMWB_CTRL_BUBBLE = 8'h00;

  // Occupancy of a stage. Bit 0 is "main entry valid" and bit 1 is
  // "skid entry valid", so both flags come straight off flops.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_MAIN  = 2'b01,
    ST_SKID  = 2'b11
  } stage_state_e;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid_if
// Valid/ready handshake bundle carrying a payload and a control field.
//   valid : producer offers an entry
//   ready : consumer can take it
//   data  : payload, DATA_W bits
//   ctrl  : control field, CTRL_W bits
// Modports: master = producer side, slave = consumer side.
// ---------------------------------------------------------------------------
interface pipe_stage_skid_if #(
  parameter int DATA_W = 160,
  parameter int CTRL_W = 12
);

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input ready);
  modport slave  (input valid, input data, input ctrl, output ready);

endinterface

// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
// Generic pipeline stage register with a 2-entry skid buffer. Full
// throughput, every output registered, no combinational path from the
// upstream side to the downstream side or from dn.ready to up.ready.
//   clk        : clock, rising edge
//   rst_n      : asynchronous reset, active low
//   flush      : synchronous squash of held and incoming entries
//   up (slave) : upstream valid/ready/data/ctrl; up.ready is registered
//   dn (master): downstream valid/ready/data/ctrl; dn.ctrl is CTRL_BUBBLE
//                whenever dn.valid is low
//   stall_cnt  : saturating count of cycles with dn.valid & !dn.ready
// ---------------------------------------------------------------------------
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = EXMEM_DATA_W,
  parameter int                CTRL_W      = EXMEM_CTRL_W,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = EXMEM_CTRL_BUBBLE,
  parameter int                STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  pipe_stage_skid_if.slave       up,
  pipe_stage_skid_if.master      dn,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam logic [STALL_CNT_W-1:0] STALL_ONE = 1;

  stage_state_e      state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
  logic [STALL_CNT_W-1:0] stall_q;

  logic acc;
  logic xfer;

  // Handshake events, computed only from registered readiness/validity
  // plus the incoming strobes.
  assign acc  = up.valid & in_ready_q;
  assign xfer = state_q[0] & dn.ready;

  // Next-state logic. Flush wins over everything. Otherwise the skid entry
  // drains first; a new entry goes to main when main is free or leaving,
  // and to the skid slot when main is stuck. Because up.ready is low while
  // the skid slot is full, acc can never be true in ST_SKID.
  always_comb begin
    state_d    = state_q;
    in_ready_d = in_ready_q;
    m_data_d   = m_data_q;
    m_ctrl_d   = m_ctrl_q;
    s_data_d   = s_data_q;
    s_ctrl_d   = s_ctrl_q;

    if (flush) begin
      state_d    = ST_EMPTY;
      m_ctrl_d   = CTRL_BUBBLE;
      in_ready_d = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_d  = ST_MAIN;
            m_data_d = up.data;
            m_ctrl_d = up.ctrl;
          end
        end
        ST_MAIN: begin
          if (acc && xfer) begin
            m_data_d = up.data;
            m_ctrl_d = up.ctrl;
          end else if (acc) begin
            state_d    = ST_SKID;
            s_data_d   = up.data;
            s_ctrl_d   = up.ctrl;
            in_ready_d = 1'b0;
          end else if (xfer) begin
            // out_data keeps its last value; only ctrl drops to the bubble.
            state_d  = ST_EMPTY;
            m_ctrl_d = CTRL_BUBBLE;
          end
        end
        ST_SKID: begin
          if (xfer) begin
            state_d    = ST_MAIN;
            m_data_d   = s_data_q;
            m_ctrl_d   = s_ctrl_q;
            in_ready_d = 1'b1;
          end
        end
        default: begin
          // Unreachable encoding: recover to an empty stage.
          state_d    = ST_EMPTY;
          m_ctrl_d   = CTRL_BUBBLE;
          in_ready_d = 1'b1;
        end
      endcase
    end
  end

  // State and storage registers. Reset discards both entries at once,
  // without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      m_data_q   <= '0;
      m_ctrl_q   <= CTRL_BUBBLE;
      s_data_q   <= '0;
      s_ctrl_q   <= CTRL_BUBBLE;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      m_data_q   <= m_data_d;
      m_ctrl_q   <= m_ctrl_d;
      s_data_q   <= s_data_d;
      s_ctrl_q   <= s_ctrl_d;
    end
  end

  // Stall counter: counts cycles where the head is offered but refused,
  // including a flush cycle, and sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (state_q[0] && !dn.ready && !(&stall_q)) begin
      stall_q <= stall_q + STALL_ONE;
    end
  end

  assign up.ready  = in_ready_q;
  assign dn.valid  = state_q[0];
  assign dn.data   = m_data_q;
  assign dn.ctrl   = m_ctrl_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_skid
// Directed bench for pipe_stage_skid (160-bit payload, 12-bit control,
// 4-bit stall counter so saturation is reachable quickly).
// ---------------------------------------------------------------------------
module tb_pipe_stage_skid;

  localparam int          DW     = 160;
  localparam int          CW     = 12;
  localparam int          SW     = 4;
  localparam logic [11:0] BUBBLE = 12'h0C0;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic [SW-1:0] stall_cnt;

  int errors;
  int checks;

  pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) up_if ();
  pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) dn_if ();

  pipe_stage_skid #(
    .DATA_W      (DW),
    .CTRL_W      (CW),
    .CTRL_BUBBLE (BUBBLE),
    .STALL_CNT_W (SW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .up        (up_if.slave),
    .dn        (dn_if.master),
    .stall_cnt (stall_cnt)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock and settle just after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Reset values while rst_n is held low.
  task automatic test_reset();
    rst_n         = 1'b0;
    flush         = 1'b0;
    up_if.valid   = 1'b0;
    up_if.data    = '0;
    up_if.ctrl    = '0;
    dn_if.ready   = 1'b0;
    #12;
    checks++; if (dn_if.valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", dn_if.valid); end
    checks++; if (up_if.ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %0b expected 1", up_if.ready); end
    checks++; if (dn_if.data !== '0) begin errors++; $display("[TB] FAIL reset_out_data: got %0h expected 0", dn_if.data); end
    checks++; if (dn_if.ctrl !== BUBBLE) begin errors++; $display("[TB] FAIL reset_out_ctrl: got %0h expected %0h", dn_if.ctrl, BUBBLE); end
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("[TB] FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
  endtask

  // Stream 1..4 with out_ready high: one-cycle latency, no bubbles.
  task automatic test_stream();
    dn_if.ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      up_if.valid = 1'b1;
      up_if.data  = DW'(i);
      up_if.ctrl  = CW'(12'h100 + i);
      cycle();
      checks++; if (dn_if.valid !== 1'b1) begin errors++; $display("[TB] FAIL stream_valid_%0d: got %0b expected 1", i, dn_if.valid); end
      checks++; if (dn_if.data !== DW'(i)) begin errors++; $display("[TB] FAIL stream_data_%0d: got %0h expected %0h", i, dn_if.data, i); end
      checks++; if (dn_if.ctrl !== CW'(12'h100 + i)) begin errors++; $display("[TB] FAIL stream_ctrl_%0d: got %0h expected %0h", i, dn_if.ctrl, 12'h100 + i); end
      checks++; if (up_if.ready !== 1'b1) begin errors++; $display("[TB] FAIL stream_in_ready_%0d: got %0b expected 1", i, up_if.ready); end
    end
    up_if.valid = 1'b0;
    cycle();
    checks++; if (dn_if.valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_drain_valid: got %0b expected 0", dn_if.valid); end
    checks++; if (dn_if.ctrl !== BUBBLE) begin errors++; $display("[TB] FAIL stream_drain_ctrl: got %0h expected %0h", dn_if.ctrl, BUBBLE); end
    checks++; if (dn_if.data !== DW'(4)) begin errors++; $display("[TB] FAIL stream_drain_data_hold: got %0h expected 4", dn_if.data); end
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("[TB] FAIL stream_stall_cnt: got %0d expected 0", stall_cnt); end
  endtask

  // A,B,C pushed against out_ready=0: A in main, B in skid, C waits.
  // Three stalled cycles, then A,B,C drain in order.
  task automatic test_backpressure();
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1;
    up_if.data  = DW'(8'hA0);
    up_if.ctrl  = 12'h00A;
    cycle();
    checks++; if (dn_if.data !== DW'(8'hA0)) begin errors++; $display("[TB] FAIL bp_a_head: got %0h expected a0", dn_if.data); end
    checks++; if (up_if.ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_after_a: got %0b expected 1", up_if.ready); end
    up_if.data = DW'(8'hB0);
    up_if.ctrl = 12'h00B;
    cycle();
    checks++; if (up_if.ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_after_b: got %0b expected 0", up_if.ready); end
    checks++; if (dn_if.data !== DW'(8'hA0)) begin errors++; $display("[TB] FAIL bp_a_still_head: got %0h expected a0", dn_if.data); end
    up_if.data = DW'(8'hC0);
    up_if.ctrl = 12'h00C;
    cycle();
    cycle();
    checks++; if (dn_if.data !== DW'(8'hA0)) begin errors++; $display("[TB] FAIL bp_hold_head: got %0h expected a0", dn_if.data); end
    checks++; if (up_if.ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_hold_ready: got %0b expected 0", up_if.ready); end
    checks++; if (stall_cnt !== 4'd3) begin errors++; $display("[TB] FAIL bp_stall_cnt: got %0d expected 3", stall_cnt); end
    dn_if.ready = 1'b1;
    cycle();
    checks++; if (dn_if.valid !== 1'b1 || dn_if.data !== DW'(8'hB0)) begin errors++; $display("[TB] FAIL bp_b_out: got valid=%0b data=%0h expected valid=1 data=b0", dn_if.valid, dn_if.data); end
    checks++; if (dn_if.ctrl !== 12'h00B) begin errors++; $display("[TB] FAIL bp_b_ctrl: got %0h expected 00b", dn_if.ctrl); end
    checks++; if (up_if.ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_reopen: got %0b expected 1", up_if.ready); end
    cycle();
    checks++; if (dn_if.valid !== 1'b1 || dn_if.data !== DW'(8'hC0)) begin errors++; $display("[TB] FAIL bp_c_out: got valid=%0b data=%0h expected valid=1 data=c0", dn_if.valid, dn_if.data); end
    up_if.valid = 1'b0;
    cycle();
    checks++; if (dn_if.valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_empty: got %0b expected 0", dn_if.valid); end
    checks++; if (stall_cnt !== 4'd3) begin errors++; $display("[TB] FAIL bp_stall_final: got %0d expected 3", stall_cnt); end
  endtask

  // Both entries full, then flush with D offered: stage empties, D dropped.
  task automatic test_flush();
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1;
    up_if.data  = DW'(8'h20);
    up_if.ctrl  = 12'h3A5;
    cycle();
    checks++; if (dn_if.ctrl !== 12'h3A5) begin errors++; $display("[TB] FAIL flush_pre_ctrl: got %0h expected 3a5", dn_if.ctrl); end
    up_if.data = DW'(8'h21);
    up_if.ctrl = 12'h021;
    cycle();
    up_if.data = DW'(8'hDD);
    up_if.ctrl = 12'h0DD;
    flush      = 1'b1;
    cycle();
    flush       = 1'b0;
    up_if.valid = 1'b0;
    checks++; if (dn_if.valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid: got %0b expected 0", dn_if.valid); end
    checks++; if (dn_if.ctrl !== BUBBLE) begin errors++; $display("[TB] FAIL flush_ctrl: got %0h expected %0h", dn_if.ctrl, BUBBLE); end
    checks++; if (up_if.ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_in_ready: got %0b expected 1", up_if.ready); end
    checks++; if (dn_if.data !== DW'(8'h20)) begin errors++; $display("[TB] FAIL flush_data_kept: got %0h expected 20", dn_if.data); end
    checks++; if (stall_cnt !== 4'd5) begin errors++; $display("[TB] FAIL flush_stall_cnt: got %0d expected 5", stall_cnt); end
    dn_if.ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      checks++; if (dn_if.valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_ghost_%0d: got valid=%0b data=%0h expected valid=0", i, dn_if.valid, dn_if.data); end
    end
  endtask

  // Idle stage: nothing appears and the counter does not move.
  task automatic test_empty();
    up_if.valid = 1'b0;
    dn_if.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++; if (dn_if.valid !== 1'b0) begin errors++; $display("[TB] FAIL empty_valid_%0d: got %0b expected 0", i, dn_if.valid); end
      checks++; if (dn_if.ctrl !== BUBBLE) begin errors++; $display("[TB] FAIL empty_ctrl_%0d: got %0h expected %0h", i, dn_if.ctrl, BUBBLE); end
      checks++; if (stall_cnt !== 4'd5) begin errors++; $display("[TB] FAIL empty_stall_%0d: got %0d expected 5", i, stall_cnt); end
    end
  endtask

  // Fresh reset, one entry held for 20 refused cycles: 4-bit counter
  // reaches 10, then 15, then stays at 15.
  task automatic test_saturation();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1;
    up_if.data  = DW'(8'h55);
    up_if.ctrl  = 12'h055;
    cycle();
    up_if.valid = 1'b0;
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("[TB] FAIL sat_start: got %0d expected 0", stall_cnt); end
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (i == 10) begin
        checks++; if (stall_cnt !== 4'd10) begin errors++; $display("[TB] FAIL sat_count_10: got %0d expected 10", stall_cnt); end
      end
      if (i == 15) begin
        checks++; if (stall_cnt !== 4'd15) begin errors++; $display("[TB] FAIL sat_count_15: got %0d expected 15", stall_cnt); end
      end
    end
    checks++; if (stall_cnt !== 4'd15) begin errors++; $display("[TB] FAIL sat_hold: got %0d expected 15", stall_cnt); end
    checks++; if (dn_if.data !== DW'(8'h55)) begin errors++; $display("[TB] FAIL sat_head: got %0h expected 55", dn_if.data); end
  endtask

  // Async reset mid-cycle with main and skid full; then a fresh entry
  // flows through with one-cycle latency and the old skid entry is gone.
  task automatic test_async_reset();
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1;
    up_if.data  = DW'(8'h31);
    up_if.ctrl  = 12'h031;
    cycle();
    up_if.data = DW'(8'h32);
    up_if.ctrl = 12'h032;
    cycle();
    up_if.valid = 1'b0;
    checks++; if (up_if.ready !== 1'b0) begin errors++; $display("[TB] FAIL areset_pre_full: got %0b expected 0", up_if.ready); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (dn_if.valid !== 1'b0) begin errors++; $display("[TB] FAIL areset_valid: got %0b expected 0", dn_if.valid); end
    checks++; if (up_if.ready !== 1'b1) begin errors++; $display("[TB] FAIL areset_in_ready: got %0b expected 1", up_if.ready); end
    checks++; if (dn_if.data !== '0) begin errors++; $display("[TB] FAIL areset_data: got %0h expected 0", dn_if.data); end
    checks++; if (dn_if.ctrl !== BUBBLE) begin errors++; $display("[TB] FAIL areset_ctrl: got %0h expected %0h", dn_if.ctrl, BUBBLE); end
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("[TB] FAIL areset_stall: got %0d expected 0", stall_cnt); end
    @(negedge clk);
    rst_n       = 1'b1;
    dn_if.ready = 1'b1;
    up_if.valid = 1'b1;
    up_if.data  = DW'(8'h40);
    up_if.ctrl  = 12'h040;
    cycle();
    up_if.valid = 1'b0;
    checks++; if (dn_if.valid !== 1'b1 || dn_if.data !== DW'(8'h40)) begin errors++; $display("[TB] FAIL areset_first_entry: got valid=%0b data=%0h expected valid=1 data=40", dn_if.valid, dn_if.data); end
    cycle();
    checks++; if (dn_if.valid !== 1'b0) begin errors++; $display("[TB] FAIL areset_no_stale: got valid=%0b data=%0h expected valid=0", dn_if.valid, dn_if.data); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    $display("[TB] starting pipe_stage_skid bench");
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_empty();
    test_saturation();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
